// File: rtl/nmcu_pkg.sv
// Shared types and default sizing for the near-memory compute unit.
// Holds the PE opcode enum used by the PE array controller and its lanes.
package nmcu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int PE_LATENCY = 2;
  localparam int CMD_DEPTH  = 4;
  localparam int RES_DEPTH  = 4;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_ADD,
    OP_MAC,
    OP_CLR
  } pe_op_e;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Command and result handshake bundle between control unit and PE array.
// Port names keep the controller-relative _i/_o suffixes.
interface pe_array_ctrl_if
  import nmcu_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter int TAG_WIDTH  = 4
) ();

  logic                            cmd_valid_i;
  logic                            cmd_ready_o;
  pe_op_e                          cmd_op_i;
  logic [NUM_LANES*DATA_WIDTH-1:0] cmd_a_i;
  logic [NUM_LANES*DATA_WIDTH-1:0] cmd_b_i;
  logic [TAG_WIDTH-1:0]            cmd_tag_i;
  logic                            res_valid_o;
  logic                            res_ready_i;
  logic [NUM_LANES*ACC_WIDTH-1:0]  res_data_o;
  logic [TAG_WIDTH-1:0]            res_tag_o;
  logic                            busy_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i,
    output cmd_tag_i, res_ready_i,
    input  cmd_ready_o, res_valid_o, res_data_o,
    input  res_tag_o, busy_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i,
    input  cmd_tag_i, res_ready_i,
    output cmd_ready_o, res_valid_o, res_data_o,
    output res_tag_o, busy_o
  );

endinterface

// File: rtl/pe_array_ctrl_lane.sv
// pe_lane: one PE lane, PE_LATENCY stages plus a signed accumulator.
// PE_ARRAY_CTRL_SAT_EN selects clamping of MAC results instead of wrap.
module pe_lane
  import nmcu_pkg::*;
#(
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter int PE_LATENCY = nmcu_pkg::PE_LATENCY
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         done,
  input  pe_op_e                       op,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  res
);

  localparam int L = PE_LATENCY-1;
  localparam logic signed [ACC_WIDTH-1:0] AMAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AMIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH:0]     sum;
  pe_op_e                         opq [PE_LATENCY];
  logic signed [ACC_WIDTH-1:0]    pq  [PE_LATENCY];
  logic signed [ACC_WIDTH-1:0]    sq  [PE_LATENCY];
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    mac;
  logic signed [ACC_WIDTH:0]      macw;

  assign prod = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
  assign sum  = (DATA_WIDTH+1)'(a) + (DATA_WIDTH+1)'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PE_LATENCY; i++) begin
        opq[i] <= OP_MUL;
        pq[i]  <= '0;
        sq[i]  <= '0;
      end
    end else begin
      opq[0] <= op;
      pq[0]  <= ACC_WIDTH'(prod);
      sq[0]  <= ACC_WIDTH'(sum);
      for (int i = 1; i < PE_LATENCY; i++) begin
        opq[i] <= opq[i-1];
        pq[i]  <= pq[i-1];
        sq[i]  <= sq[i-1];
      end
    end
  end

  // Extra top bit exposes signed overflow of acc + product.
  always_comb begin
    macw = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(pq[L]);
    mac  = macw[ACC_WIDTH-1:0];
`ifdef PE_ARRAY_CTRL_SAT_EN
    if (macw[ACC_WIDTH] != macw[ACC_WIDTH-1])
      mac = macw[ACC_WIDTH] ? AMIN : AMAX;
`endif
  end

  always_comb begin
    res = '0;
    unique case (1'b1)
      (opq[L] == OP_MUL): res = pq[L];
      (opq[L] == OP_ADD): res = sq[L];
      (opq[L] == OP_MAC): res = mac;
      default:            res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (done && opq[L] == OP_MAC)
      acc <= mac;
    else if (done && opq[L] == OP_CLR)
      acc <= '0;
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// PE array controller: command FIFO, credit-checked in-order issue,
// NUM_LANES pe_lane instances, FWFT result FIFO. Macro: PE_ARRAY_CTRL_SAT_EN.
module pe_array_ctrl
  import nmcu_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter int PE_LATENCY = nmcu_pkg::PE_LATENCY,
  parameter int CMD_DEPTH  = nmcu_pkg::CMD_DEPTH,
  parameter int RES_DEPTH  = nmcu_pkg::RES_DEPTH,
  parameter int TAG_WIDTH  = 4
) (
  input logic            clk,
  input logic            rst_n,
  pe_array_ctrl_if.slave bus
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RES_DEPTH);
  localparam int VW  = NUM_LANES*DATA_WIDTH;
  localparam int RW  = NUM_LANES*ACC_WIDTH;

  pe_op_e               cop  [CMD_DEPTH];
  logic [VW-1:0]        ca   [CMD_DEPTH];
  logic [VW-1:0]        cb   [CMD_DEPTH];
  logic [TAG_WIDTH-1:0] ct   [CMD_DEPTH];
  logic [RW-1:0]        rdat [RES_DEPTH];
  logic [TAG_WIDTH-1:0] rtag [RES_DEPTH];
  logic [TAG_WIDTH-1:0] tq   [PE_LATENCY];
  logic [PE_LATENCY-1:0] vld;

  logic [CAW:0]  cwp, crp, ccnt;
  logic [RAW:0]  rwp, rrp, used;
  logic          cfull, cempty, cpush, issue;
  logic          rempty, rpop, done;
  pe_op_e        hop;
  logic [VW-1:0] ha, hb;
  logic [RW-1:0] lres;

  assign ccnt   = cwp - crp;
  assign cfull  = ccnt == (CAW+1)'(CMD_DEPTH);
  assign cempty = cwp == crp;
  assign cpush  = bus.cmd_valid_i && !cfull;
  // used = in-flight + stored results; keeps the result FIFO from overflowing
  assign issue  = !cempty && (used < (RAW+1)'(RES_DEPTH));
  assign rempty = rwp == rrp;
  assign rpop   = !rempty && bus.res_ready_i;
  assign done   = vld[PE_LATENCY-1];

  assign hop = cop[crp[CAW-1:0]];
  assign ha  = ca[crp[CAW-1:0]];
  assign hb  = cb[crp[CAW-1:0]];

  always_ff @(posedge clk) begin
    if (cpush) begin
      cop[cwp[CAW-1:0]] <= bus.cmd_op_i;
      ca[cwp[CAW-1:0]]  <= bus.cmd_a_i;
      cb[cwp[CAW-1:0]]  <= bus.cmd_b_i;
      ct[cwp[CAW-1:0]]  <= bus.cmd_tag_i;
    end
    if (done) begin
      rdat[rwp[RAW-1:0]] <= lres;
      rtag[rwp[RAW-1:0]] <= tq[PE_LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cwp  <= '0;
      crp  <= '0;
      rwp  <= '0;
      rrp  <= '0;
      used <= '0;
      vld  <= '0;
      for (int i = 0; i < PE_LATENCY; i++)
        tq[i] <= '0;
    end else begin
      if (cpush) cwp <= cwp + 1'b1;
      if (issue) crp <= crp + 1'b1;
      if (done)  rwp <= rwp + 1'b1;
      if (rpop)  rrp <= rrp + 1'b1;
      if (issue && !rpop)
        used <= used + 1'b1;
      else if (!issue && rpop)
        used <= used - 1'b1;
      vld[0] <= issue;
      tq[0]  <= ct[crp[CAW-1:0]];
      for (int i = 1; i < PE_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        tq[i]  <= tq[i-1];
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pe_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .PE_LATENCY (PE_LATENCY)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .done  (done),
      .op    (hop),
      .a     (ha[l*DATA_WIDTH +: DATA_WIDTH]),
      .b     (hb[l*DATA_WIDTH +: DATA_WIDTH]),
      .res   (lres[l*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  assign bus.cmd_ready_o = !cfull;
  assign bus.res_valid_o = !rempty;
  assign bus.res_data_o  = rempty ? '0 : rdat[rrp[RAW-1:0]];
  assign bus.res_tag_o   = rempty ? '0 : rtag[rrp[RAW-1:0]];
  assign bus.busy_o      = !cempty || (used != '0);

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl (4 lanes, 8-bit operands, 16-bit acc).
// Expected results follow PE_ARRAY_CTRL_SAT_EN when it is defined.
module tb_pe_array_ctrl;
  import nmcu_pkg::*;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   cyc;
  int   acc_cnt;
  int   npop;
  exp_t exp_q[$];
  int   pop_cyc[$];

  pe_array_ctrl_if #(
    .NUM_LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .TAG_WIDTH(4)
  ) bus ();

  pe_array_ctrl #(
    .NUM_LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .PE_LATENCY(2),
    .CMD_DEPTH(4), .RES_DEPTH(4), .TAG_WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pd(int v0, int v1, int v2, int v3);
    return {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  function automatic logic [63:0] pr(int v0, int v1, int v2, int v3);
    return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.cmd_valid_i && bus.cmd_ready_o) acc_cnt++;
  end

  // Monitor: pops the scoreboard whenever a result is consumed.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
      npop++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_extra: got tag %0d want no result", bus.res_tag_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", bus.res_data_o, e.d);
        chk("res_tag", 64'(bus.res_tag_o), 64'(e.t));
      end
    end
  end

  task automatic send(pe_op_e op, logic [31:0] a, logic [31:0] b,
                      logic [3:0] tag, logic [63:0] exp);
    int n;
    exp_q.push_back('{d: exp, t: tag});
    bus.cmd_op_i    = op;
    bus.cmd_a_i     = a;
    bus.cmd_b_i     = b;
    bus.cmd_tag_i   = tag;
    bus.cmd_valid_i = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) break;
    end
    if (n == 200) begin
      n_chk++;
      $display("FAIL send_timeout tag %0d: got ready 0 want 1", tag);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!bus.busy_o && exp_q.size() == 0) break;
    end
    if (n == 200) begin
      n_chk++;
      $display("FAIL %s_idle: got busy %0d pending %0d want 0 0",
               nm, bus.busy_o, exp_q.size());
    end
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'd1);
    chk({nm, "_res_valid"}, 64'(bus.res_valid_o), 64'd0);
    chk({nm, "_res_data"}, bus.res_data_o, 64'd0);
    chk({nm, "_res_tag"}, 64'(bus.res_tag_o), 64'd0);
    chk({nm, "_busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    int k, base, pbase, n;
    logic [63:0] sat3;
    n_chk = 0; n_pass = 0; cyc = 0; acc_cnt = 0; npop = 0;
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = OP_MUL;
    bus.cmd_a_i     = '0;
    bus.cmd_b_i     = '0;
    bus.cmd_tag_i   = '0;
    bus.res_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single MUL: latency, tag, busy fall
    send(OP_MUL, pd(3, 7, -8, 127), pd(-4, 6, -8, -128), 4'd5,
         pr(-12, 42, 64, -16256));
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.res_valid_o) break;
    end
    chk("mul_latency", 64'(k - 1), 64'd3);
    chk("mul_busy_held", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    chk("mul_busy_fall", 64'(bus.busy_o), 64'd0);

    // CLR then back-to-back MACs
    @(posedge clk); #1;
    pop_cyc.delete();
    send(OP_CLR, pd(9, 9, 9, 9), pd(9, 9, 9, 9), 4'd1, pr(0, 0, 0, 0));
    for (int i = 1; i <= 3; i++)
      send(OP_MAC, pd(2, 2, 2, -3), pd(5, 5, 5, 4), 4'(1 + i),
           pr(10*i, 10*i, 10*i, -12*i));
    wait_idle("mac");
    chk("mac_pops", 64'(pop_cyc.size()), 64'd4);
    for (int i = 0; i + 1 < pop_cyc.size(); i++)
      chk("mac_gap", 64'(pop_cyc[i+1] - pop_cyc[i]), 64'd1);

    // Backpressure: 10 commands with the consumer stalled
    @(posedge clk); #1;
    bus.res_ready_i = 1'b0;
    base  = acc_cnt;
    pbase = npop;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(OP_ADD, pd(i, -i, 2*i, 0), pd(1, 1, 1, 1), 4'(i),
               pr(i + 1, 1 - i, 2*i + 1, 1));
      end
    join_none
    repeat (30) @(negedge clk);
    chk("stall_accepts", 64'(acc_cnt - base), 64'd8);
    chk("stall_ready_low", 64'(bus.cmd_ready_o), 64'd0);
    chk("stall_valid", 64'(bus.res_valid_o), 64'd1);
    chk("stall_head_tag", 64'(bus.res_tag_o), 64'd0);
    chk("stall_head_data", bus.res_data_o, pr(1, 1, 1, 1));
    repeat (5) @(negedge clk);
    chk("stall_hold_tag", 64'(bus.res_tag_o), 64'd0);
    chk("stall_hold_data", bus.res_data_o, pr(1, 1, 1, 1));
    chk("stall_no_pop", 64'(npop - pbase), 64'd0);
    @(posedge clk); #1;
    bus.res_ready_i = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (acc_cnt - base == 10) break;
    end
    chk("stall_all_accepted", 64'(acc_cnt - base), 64'd10);
    wait_idle("stall");
    chk("stall_all_out", 64'(npop - pbase), 64'd10);

    // Accumulator overflow: clamp or wrap
`ifdef PE_ARRAY_CTRL_SAT_EN
    sat3 = pr(32767, -32768, 3, 0);
`else
    sat3 = pr(-17149, 16768, 3, 0);
`endif
    @(posedge clk); #1;
    send(OP_CLR, pd(0, 0, 0, 0), pd(0, 0, 0, 0), 4'd10, pr(0, 0, 0, 0));
    send(OP_MAC, pd(127, -128, 1, 0), pd(127, 127, 1, 0), 4'd11,
         pr(16129, -16256, 1, 0));
    send(OP_MAC, pd(127, -128, 1, 0), pd(127, 127, 1, 0), 4'd12,
         pr(32258, -32512, 2, 0));
    send(OP_MAC, pd(127, -128, 1, 0), pd(127, 127, 1, 0), 4'd13, sat3);
    wait_idle("sat");

    // Reset with the accumulator at 30 and commands in flight
    @(posedge clk); #1;
    send(OP_CLR, pd(0, 0, 0, 0), pd(0, 0, 0, 0), 4'd0, pr(0, 0, 0, 0));
    for (int i = 1; i <= 3; i++)
      send(OP_MAC, pd(2, 2, 2, 2), pd(5, 5, 5, 5), 4'(i),
           pr(10*i, 10*i, 10*i, 10*i));
    wait_idle("pre_rst");
    @(posedge clk); #1;
    send(OP_MUL, pd(1, 1, 1, 1), pd(3, 3, 3, 3), 4'd7, pr(3, 3, 3, 3));
    send(OP_MUL, pd(1, 1, 1, 1), pd(4, 4, 4, 4), 4'd8, pr(4, 4, 4, 4));
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(OP_MAC, pd(1, 1, 1, 1), pd(1, 1, 1, 1), 4'd9, pr(1, 1, 1, 1));
    wait_idle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Multi-lane, pipelined command/result controller for the PE array, positioned between the control unit and the PE datapath. It queues operand-vector commands, issues them in order to `NUM_LANES` identical lanes with a fixed pipeline latency, and keeps a per-lane accumulator for MAC operations. Results go into a credit-protected result FIFO with full valid/ready backpressure. Each result carries a tag so the control unit can match it to its command.

## Interface
- `NUM_LANES`, default 4: parallel PE lanes.
- `DATA_WIDTH`, default `nmcu_pkg::DATA_WIDTH`: signed operand width per lane.
- `ACC_WIDTH`, default `2*DATA_WIDTH+8`: signed result/accumulator width per lane.
- `PE_LATENCY`, default 2: issue-to-result pipeline stages, ≥1.
- `CMD_DEPTH`, default 4: command FIFO entries, power of 2, ≥2.
- `RES_DEPTH`, default 4: result FIFO entries, power of 2, ≥2.
- `TAG_WIDTH`, default 4: command tag width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  command FIFO not full.
- `cmd_op_i`  in  `$bits(pe_op_e)`  operation.
- `cmd_a_i`, `cmd_b_i`  in  `NUM_LANES*DATA_WIDTH` each  lane operands; lane i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `cmd_tag_i`  in  `TAG_WIDTH`  tag returned with the result.
- `res_valid_o`  out  1  result FIFO not empty.
- `res_ready_i`  in  1  consumer accepts the result.
- `res_data_o`  out  `NUM_LANES*ACC_WIDTH`  lane results, packed the same way as the operands.
- `res_tag_o`  out  `TAG_WIDTH`  tag of the head result.
- `busy_o`  out  1  any command queued, in flight, or result pending.

## Operation
- Accept a command when `cmd_valid_i && cmd_ready_o`. `cmd_ready_o = !cmd_fifo_full`. A full FIFO never accepts, even if it pops in the same cycle.
- Issue: the head of the command FIFO issues when `in_flight + res_count < RES_DEPTH` (credit check). At most one issue per cycle. Commands issue strictly in order.
- Per-lane arithmetic is signed two's complement. Products and sums are sign-extended to `ACC_WIDTH` before combining.
  - `OP_MUL`: result = a*b. Accumulator unchanged.
  - `OP_ADD`: result = a+b. Accumulator unchanged.
  - `OP_MAC`: acc ← acc + a*b. Result = new acc.
  - `OP_CLR`: acc ← 0. Result = 0.
- The accumulator updates in the final pipeline stage. Back-to-back MACs therefore see every preceding update; no stall is needed.
- Result FIFO is first-word-fall-through. It pops on `res_valid_o && res_ready_i`. Push and pop in the same cycle are legal when full or empty.
- The credit check guarantees the result FIFO never overflows, so no result is ever dropped.
- Reset, asynchronous at any time including mid-operation:
  - flushes both FIFOs;
  - discards in-flight commands;
  - clears all accumulators and credits.

## Timing
- Reset values: `cmd_ready_o`=1, `res_valid_o`=0, `res_data_o`=0, `res_tag_o`=0, `busy_o`=0.
- Latency with no backpressure: command accepted at edge t0, issued at edge t0+1, written to the result FIFO at edge t0+1+`PE_LATENCY`. `res_valid_o` is high right after that edge. Default latency is 3 cycles.
- Throughput: 1 command per cycle sustained while `res_ready_i`=1.
- Stall: with `res_ready_i` held 0, exactly `RES_DEPTH` results are produced. Further commands then fill the command FIFO, after which `cmd_ready_o` drops.
- `res_data_o` and `res_tag_o` hold stable while `res_valid_o && !res_ready_i`.
- `busy_o` falls in the cycle after the last result pops.

## Configuration
- `PE_ARRAY_CTRL_SAT_EN` defined: `OP_ADD`/`OP_MAC` results and the accumulator clamp to the signed `ACC_WIDTH` range [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- Not defined: results and accumulator wrap modulo 2^`ACC_WIDTH`.
- `OP_MUL` is unaffected either way, since its result always fits.

## Structure
- `nmcu_pkg` holds the `pe_op_e` enum (`OP_MUL`, `OP_ADD`, `OP_MAC`, `OP_CLR`) and the default `PE_LATENCY`/depth constants.
- Sub-module `pe_lane`: one lane's `PE_LATENCY`-stage datapath plus its accumulator. It is instantiated `NUM_LANES` times by generate.
- FIFOs, the credit counter and the tag pipeline are local to `pe_array_ctrl`.

## Test plan
- Reset, then one `OP_MUL` with lane0 a=3, b=−4, tag=5 and `res_ready_i`=1 → `res_valid_o` 3 cycles after accept; lane0 result = −12; tag = 5; `busy_o` low one cycle after the pop.
- `OP_CLR`, then 3× `OP_MAC` with a=2, b=5 back-to-back → results 0, 10, 20, 30, in order, on consecutive cycles.
- `res_ready_i`=0, push 10 commands → exactly 4 results held; `cmd_ready_o` goes low after 8 accepts. Release `res_ready_i` → all 10 results emerge in tag order with none lost.
- `ACC_WIDTH`=16, `DATA_WIDTH`=8, 3× `OP_MAC` 127*127 → results 16129, 32258, then 32767 with `PE_ARRAY_CTRL_SAT_EN` or −17149 without.
- Full result FIFO with a simultaneous pop and issue → occupancy unchanged and no result dropped.
- Assert `rst_n` with 2 commands in flight and a MAC accumulator at 30 → all outputs return to reset values. A following `OP_MAC` 1*1 returns 1.
